// File: rtl/block_dispatcher_if.sv
// Launch/completion bundle between the host-side control, the block dispatcher
// and the per-core start/reset/block-id inputs.
interface block_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int TCW       = 3
);
  logic                   start;
  logic [7:0]             thread_count;
  logic [NUM_CORES-1:0]   core_done;
  logic [NUM_CORES-1:0]   core_start;
  logic [NUM_CORES-1:0]   core_reset;
  logic [NUM_CORES*8-1:0] core_block_id;
  logic [NUM_CORES*TCW-1:0] core_thread_count;
  logic                   done;

  modport master (
    output start, thread_count, core_done,
    input  core_start, core_reset, core_block_id, core_thread_count, done
  );

  modport slave (
    input  start, thread_count, core_done,
    output core_start, core_reset, core_block_id, core_thread_count, done
  );
endinterface

// File: rtl/block_dispatcher.sv
// Splits a kernel launch into fixed-size thread blocks and hands them out in
// order to the lowest-index free core, raising done once all blocks complete.
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  block_dispatcher_if.slave bus
);
  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int TCW      = LOG2_TPB + 1;
  localparam logic [8:0]     TPB9   = 9'(THREADS_PER_BLOCK);
  localparam logic [TCW-1:0] TPB_TC = TCW'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [7:0]           latched_tc_reg, latched_tc_next;
  logic [8:0]           total_blocks_reg, total_blocks_next;
  logic [8:0]           blocks_dispatched_reg, blocks_dispatched_next;
  logic [8:0]           blocks_done_reg, blocks_done_next;
  logic                 all_done_reg, all_done_next;
  logic                 done_reg, done_next;
  logic [NUM_CORES-1:0] core_start_reg, core_start_next;
  logic [NUM_CORES-1:0] core_reset_reg, core_reset_next;
  logic [7:0]           block_id_reg [NUM_CORES];
  logic [7:0]           block_id_next [NUM_CORES];
  logic [TCW-1:0]       blk_tc_reg [NUM_CORES];
  logic [TCW-1:0]       blk_tc_next [NUM_CORES];

  logic [8:0]     launch_blocks;
  logic [8:0]     last_base;
  logic [8:0]     last_threads;
  logic [TCW-1:0] dispatch_tc;
  logic [8:0]     complete_cnt;
  logic           found;

  assign launch_blocks = ({1'b0, bus.thread_count} + TPB9 - 9'd1) >> LOG2_TPB;
  // Threads left over for the final block; only meaningful once total_blocks >= 1.
  assign last_base    = (total_blocks_reg - 9'd1) << LOG2_TPB;
  assign last_threads = {1'b0, latched_tc_reg} - last_base;
  assign dispatch_tc  = (blocks_dispatched_reg == total_blocks_reg - 9'd1)
                        ? last_threads[TCW-1:0] : TPB_TC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = (bus.thread_count == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (all_done_reg) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.start) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    latched_tc_next        = latched_tc_reg;
    total_blocks_next      = total_blocks_reg;
    blocks_dispatched_next = blocks_dispatched_reg;
    blocks_done_next       = blocks_done_reg;
    done_next              = done_reg;
    core_start_next        = core_start_reg;
    core_reset_next        = core_reset_reg;
    block_id_next          = block_id_reg;
    blk_tc_next            = blk_tc_reg;
    complete_cnt           = 9'd0;
    found                  = 1'b0;
    all_done_next          = (state_reg == S_RUN) && (total_blocks_reg != 9'd0) &&
                             (blocks_done_reg == total_blocks_reg);

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          latched_tc_next        = bus.thread_count;
          total_blocks_next      = launch_blocks;
          blocks_dispatched_next = 9'd0;
          blocks_done_next       = 9'd0;
          done_next              = (bus.thread_count == 8'd0);
        end
      end
      S_RUN: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (core_start_reg[i] && bus.core_done[i]) begin
            core_start_next[i] = 1'b0;
            core_reset_next[i] = 1'b1;
            complete_cnt       = complete_cnt + 9'd1;
          end
        end
        blocks_done_next = blocks_done_reg + complete_cnt;

        // Free cores are judged on registered core_reset, so a core freed this
        // edge is only eligible from the next one.
        if (blocks_dispatched_reg < total_blocks_reg) begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && core_reset_reg[i]) begin
              found                  = 1'b1;
              core_reset_next[i]     = 1'b0;
              core_start_next[i]     = 1'b1;
              block_id_next[i]       = blocks_dispatched_reg[7:0];
              blk_tc_next[i]         = dispatch_tc;
              blocks_dispatched_next = blocks_dispatched_reg + 9'd1;
            end
          end
        end

        if (all_done_reg) begin
          done_next       = 1'b1;
          core_start_next = '0;
          core_reset_next = '1;
        end
      end
      S_DONE: begin
        done_next       = bus.start;
        core_start_next = '0;
        core_reset_next = '1;
      end
      default: begin
        done_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latched_tc_reg        <= 8'd0;
      total_blocks_reg      <= 9'd0;
      blocks_dispatched_reg <= 9'd0;
      blocks_done_reg       <= 9'd0;
      all_done_reg          <= 1'b0;
      done_reg              <= 1'b0;
      core_start_reg        <= '0;
      core_reset_reg        <= '1;
      for (int i = 0; i < NUM_CORES; i++) begin
        block_id_reg[i] <= 8'd0;
        blk_tc_reg[i]   <= '0;
      end
    end else begin
      latched_tc_reg        <= latched_tc_next;
      total_blocks_reg      <= total_blocks_next;
      blocks_dispatched_reg <= blocks_dispatched_next;
      blocks_done_reg       <= blocks_done_next;
      all_done_reg          <= all_done_next;
      done_reg              <= done_next;
      core_start_reg        <= core_start_next;
      core_reset_reg        <= core_reset_next;
      block_id_reg          <= block_id_next;
      blk_tc_reg            <= blk_tc_next;
    end
  end

  assign bus.core_start = core_start_reg;
  assign bus.core_reset = core_reset_reg;
  assign bus.done       = done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core_out
      assign bus.core_block_id[gi*8 +: 8]         = block_id_reg[gi];
      assign bus.core_thread_count[gi*TCW +: TCW] = blk_tc_reg[gi];
    end
  endgenerate
endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with NUM_CORES=2, THREADS_PER_BLOCK=4.
module tb_block_dispatcher;
  localparam int NC  = 2;
  localparam int TCW = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  block_dispatcher_if #(.NUM_CORES(NC), .TCW(TCW)) bus ();

  block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.thread_count = 8'd0; bus.core_done = '0;
    reset = 1'b0;
    #12;
    n_checks++; if (bus.core_start !== 2'b00) begin n_fail++; $display("FAIL reset_start got %b want 00", bus.core_start); end
    n_checks++; if (bus.core_reset !== 2'b11) begin n_fail++; $display("FAIL reset_creset got %b want 11", bus.core_reset); end
    n_checks++; if (bus.core_block_id !== 16'h0) begin n_fail++; $display("FAIL reset_id got %h want 0000", bus.core_block_id); end
    n_checks++; if (bus.core_thread_count !== 6'd0) begin n_fail++; $display("FAIL reset_tc got %h want 0", bus.core_thread_count); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    #4 reset = 1'b1;
    tick();
    $display("test_reset: outputs at reset values checked");
  endtask

  task automatic test_two_blocks();
    bus.start = 1'b1; bus.thread_count = 8'd8;
    tick();
    n_checks++; if (bus.core_start !== 2'b00) begin n_fail++; $display("FAIL tb_latch_start got %b want 00", bus.core_start); end
    tick();
    n_checks++; if (bus.core_start !== 2'b01 || bus.core_block_id[7:0] !== 8'd0 || bus.core_thread_count[2:0] !== 3'd4) begin
      n_fail++; $display("FAIL tb_core0 got start=%b id=%0d tc=%0d want 01/0/4", bus.core_start, bus.core_block_id[7:0], bus.core_thread_count[2:0]); end
    tick();
    n_checks++; if (bus.core_start !== 2'b11 || bus.core_block_id[15:8] !== 8'd1 || bus.core_thread_count[5:3] !== 3'd4) begin
      n_fail++; $display("FAIL tb_core1 got start=%b id=%0d tc=%0d want 11/1/4", bus.core_start, bus.core_block_id[15:8], bus.core_thread_count[5:3]); end
    bus.core_done = 2'b01;
    tick();
    n_checks++; if (bus.core_reset !== 2'b01 || bus.core_start !== 2'b10) begin
      n_fail++; $display("FAIL tb_c0_done got reset=%b start=%b want 01/10", bus.core_reset, bus.core_start); end
    bus.core_done = 2'b10;
    tick();
    bus.core_done = 2'b00;
    n_checks++; if (bus.core_reset !== 2'b11) begin n_fail++; $display("FAIL tb_c1_done got %b want 11", bus.core_reset); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL tb_done_early got %b want 0", bus.done); end
    tick();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL tb_done got %b want 1", bus.done); end
    tick();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL tb_done_hold got %b want 1", bus.done); end
    bus.start = 1'b0;
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL tb_idle got %b want 0", bus.done); end
    $display("test_two_blocks: 8 threads, 2 blocks dispatched and completed");
  endtask

  task automatic test_partial_block();
    bus.start = 1'b1; bus.thread_count = 8'd10;
    tick(); tick(); tick();
    n_checks++; if (bus.core_start !== 2'b11 || bus.core_block_id !== 16'h0100) begin
      n_fail++; $display("FAIL pb_first got start=%b ids=%h want 11/0100", bus.core_start, bus.core_block_id); end
    bus.core_done = 2'b01;
    tick();
    bus.core_done = 2'b00;
    n_checks++; if (bus.core_reset !== 2'b01) begin n_fail++; $display("FAIL pb_c0_free got %b want 01", bus.core_reset); end
    tick();
    n_checks++; if (bus.core_start !== 2'b11 || bus.core_block_id[7:0] !== 8'd2 || bus.core_thread_count[2:0] !== 3'd2) begin
      n_fail++; $display("FAIL pb_block2 got start=%b id=%0d tc=%0d want 11/2/2", bus.core_start, bus.core_block_id[7:0], bus.core_thread_count[2:0]); end
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL pb_done_early got %b want 0", bus.done); end
    tick();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL pb_done got %b want 1", bus.done); end
    bus.start = 1'b0;
    tick();
    $display("test_partial_block: 10 threads, last block of 2 threads");
  endtask

  task automatic test_zero_threads();
    bus.start = 1'b1; bus.thread_count = 8'd0;
    tick();
    n_checks++; if (bus.done !== 1'b1 || bus.core_start !== 2'b00) begin
      n_fail++; $display("FAIL zt_done got done=%b start=%b want 1/00", bus.done, bus.core_start); end
    bus.start = 1'b0;
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zt_idle got %b want 0", bus.done); end
    tick();
    n_checks++; if (bus.core_start !== 2'b00) begin n_fail++; $display("FAIL zt_nostart got %b want 00", bus.core_start); end
    $display("test_zero_threads: empty launch completes immediately");
  endtask

  task automatic test_simultaneous_done();
    bus.start = 1'b1; bus.thread_count = 8'd8;
    tick(); tick(); tick();
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    n_checks++; if (bus.core_reset !== 2'b11 || bus.core_start !== 2'b00) begin
      n_fail++; $display("FAIL sd_both got reset=%b start=%b want 11/00", bus.core_reset, bus.core_start); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL sd_done_early got %b want 0", bus.done); end
    tick();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL sd_done got %b want 1", bus.done); end
    bus.start = 1'b0;
    tick();
    $display("test_simultaneous_done: both cores complete on one edge");
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1; bus.thread_count = 8'd8;
    tick(); tick();
    #2 reset = 1'b0;
    bus.start = 1'b0;
    #1;
    n_checks++; if (bus.core_start !== 2'b00 || bus.core_reset !== 2'b11 || bus.core_block_id !== 16'h0 ||
                    bus.core_thread_count !== 6'd0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL rm_async got start=%b reset=%b id=%h tc=%h done=%b want 00/11/0000/00/0",
        bus.core_start, bus.core_reset, bus.core_block_id, bus.core_thread_count, bus.done); end
    #2 reset = 1'b1;
    tick();
    bus.start = 1'b1; bus.thread_count = 8'd4;
    tick(); tick();
    n_checks++; if (bus.core_reset !== 2'b10 || bus.core_block_id[7:0] !== 8'd0 || bus.core_thread_count[2:0] !== 3'd4) begin
      n_fail++; $display("FAIL rm_single got reset=%b id=%0d tc=%0d want 10/0/4", bus.core_reset, bus.core_block_id[7:0], bus.core_thread_count[2:0]); end
    bus.core_done = 2'b01;
    tick();
    bus.core_done = 2'b00;
    tick(); tick();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rm_done got %b want 1", bus.done); end
    bus.start = 1'b0;
    tick();
    $display("test_reset_mid_run: async reset then single-block launch");
  endtask

  task automatic test_ignored_inputs();
    bus.start = 1'b1; bus.thread_count = 8'd8;
    tick();
    bus.thread_count = 8'd20;
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    n_checks++; if (bus.core_start !== 2'b01) begin n_fail++; $display("FAIL ig_spurious got %b want 01", bus.core_start); end
    tick(); tick();
    n_checks++; if (bus.core_start !== 2'b11 || bus.core_block_id !== 16'h0100) begin
      n_fail++; $display("FAIL ig_ids got start=%b ids=%h want 11/0100", bus.core_start, bus.core_block_id); end
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    tick();
    n_checks++; if (bus.core_start !== 2'b00) begin n_fail++; $display("FAIL ig_no_third got %b want 00", bus.core_start); end
    tick();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ig_done got %b want 1", bus.done); end
    bus.start = 1'b0;
    tick();
    $display("test_ignored_inputs: spurious done and thread_count change ignored");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_two_blocks();
    test_partial_block();
    test_zero_threads();
    test_simultaneous_done();
    test_reset_mid_run();
    test_ignored_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
